// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port round-robin share of one ALU plus a result register.
// ALU_SHARE_ARB_FIXED_PRIO_EN selects fixed priority (req0 always wins).
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  logic slot_free;
  logic gnt0;
  logic gnt1;
  logic [TAG_W-1:0] gnt_tag;

  assign slot_free = rst_n && (!rsp_valid || rsp_ready);

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  // req0 always wins; req1 only when req0 idle
  always_comb begin
    gnt0 = slot_free && req0_valid;
    gnt1 = slot_free && req1_valid && !req0_valid;
  end
`else
  logic last;

  // On contention the side that did not win last time goes
  always_comb begin
    gnt0 = slot_free && req0_valid
        && (!req1_valid || last);
    gnt1 = slot_free && req1_valid
        && (!req0_valid || !last);
  end

  // last tracks the most recent winner, moves only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Steer winner onto the ALU; idle drive is ADD 0+0
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    gnt_tag  = '0;
    unique case (1'b1)
      gnt0: begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_op;
        gnt_tag  = req0_tag;
      end
      gnt1: begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_ctrl = req1_op;
        gnt_tag  = req1_tag;
      end
      default: begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        gnt_tag  = '0;
      end
    endcase
  end

  // Capture on grant, release on drain; grant wins over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (gnt0 || gnt1) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_id    <= gnt1;
      rsp_tag   <= gnt_tag;
      rsp_err   <= (alu_ctrl > 4'd9);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed table plus corner sequences for alu_share_arb.
// Includes a behavioural ALU on the shared port.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU
  always_comb begin
    alu_out = 32'd0;
    case (alu_ctrl)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a << alu_b[4:0];
      4'd3: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd4: alu_out = alu_a >> alu_b[4:0];
      4'd5: alu_out = alu_a | alu_b;
      4'd6: alu_out = alu_a ^ alu_b;
      4'd7: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd8: alu_out = {31'd0, alu_a < alu_b};
      4'd9: alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic [3:0]  op0, tag0;
    logic [31:0] a1, b1;
    logic [3:0]  op1, tag1;
    logic        rr;
    logic        e_rdy0, e_rdy1;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_id;
    logic [3:0]  e_tag;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic drive(input logic v0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [3:0] op0,
                       input logic [3:0] t0, input logic v1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] op1, input logic [3:0] t1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req0_op = op0; req0_tag = t0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    req1_op = op1; req1_tag = t1;
    rsp_ready = rr;
  endtask

  function automatic vec_t mk(
      input logic v0, input logic [31:0] a0, input logic [31:0] b0,
      input logic [3:0] op0, input logic [3:0] t0,
      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
      input logic [3:0] op1, input logic [3:0] t1, input logic rr,
      input logic r0, input logic r1, input logic ev,
      input logic [31:0] ed, input logic eid, input logic [3:0] et,
      input logic ee);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0; v.tag0 = t0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1; v.tag1 = t1;
    v.rr = rr; v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_valid = ev;
    v.e_data = ed; v.e_id = eid; v.e_tag = et; v.e_err = ee;
    return v;
  endfunction

  initial begin
    // req0 SUB 7-5
    tbl[0] = mk(1,7,5,1,3, 0,0,0,0,0, 1, 1,0, 1,32'd2,0,4'd3,0);
    // req1 undefined op 12
    tbl[1] = mk(0,0,0,0,0, 1,32'hFFFF_FFFF,0,12,5, 1,
                0,1, 1,32'd0,1,4'd5,1);
    // contention: req0 ADD 1+1, req1 SLL 1<<4
    tbl[2] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 1,0, 1,32'd2,0,4'd1,0);
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    tbl[3] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 1,0, 1,32'd2,0,4'd1,0);
`else
    tbl[3] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 0,1, 1,32'd16,1,4'd2,0);
`endif
    tbl[4] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 1,0, 1,32'd2,0,4'd1,0);
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    tbl[5] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 1,0, 1,32'd2,0,4'd1,0);
`else
    tbl[5] = mk(1,1,1,0,1, 1,1,4,2,2, 1, 0,1, 1,32'd16,1,4'd2,0);
`endif
    // SLT(-1,1)=1, SLTU(-1,1)=0
    tbl[6] = mk(1,32'hFFFF_FFFF,1,7,6, 0,0,0,0,0, 1,
                1,0, 1,32'd1,0,4'd6,0);
    tbl[7] = mk(1,32'hFFFF_FFFF,1,8,7, 0,0,0,0,0, 1,
                1,0, 1,32'd0,0,4'd7,0);
    // req1 SRA -16>>>2
    tbl[8] = mk(0,0,0,0,0, 1,32'hFFFF_FFF0,2,3,8, 1,
                0,1, 1,32'hFFFF_FFFC,1,4'd8,0);
    // idle drain: valid drops, fields hold
    tbl[9] = mk(0,0,0,0,0, 0,0,0,0,0, 1,
                0,0, 0,32'hFFFF_FFFC,1,4'd8,0);

    drive(0,0,0,0,0, 0,0,0,0,0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id_tag_err", {27'd0, rsp_id, rsp_tag}, {27'd0, rsp_err, 4'd0});
    chk("rst_rdy", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", {31'd0, rsp_valid}, 0);
      chk("idle_rdy", {30'd0, req0_ready, req1_ready}, 0);
      chk("idle_alu", alu_a | alu_b | {28'd0, alu_ctrl}, 0);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].op0, tbl[i].tag0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].op1, tbl[i].tag1,
            tbl[i].rr);
      #1;
      chk($sformatf("v%0d_rdy", i), {30'd0, req0_ready, req1_ready},
          {30'd0, tbl[i].e_rdy0, tbl[i].e_rdy1});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, rsp_valid},
          {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_data", i), rsp_data, tbl[i].e_data);
      chk($sformatf("v%0d_id_tag_err", i),
          {26'd0, rsp_id, rsp_tag, rsp_err},
          {26'd0, tbl[i].e_id, tbl[i].e_tag, tbl[i].e_err});
    end

    // backpressure: capture 3+4 with no consumer
    @(negedge clk);
    drive(1,3,4,0,9, 0,0,0,0,0, 0);
    @(posedge clk); #1;
    chk("bp_cap", rsp_data, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0,0,0,0,0, 1,32'hF0,32'h0F,6,10, 0);
      #1;
      chk("bp_rdy", {30'd0, req0_ready, req1_ready}, 0);
      chk("bp_alu", {28'd0, alu_ctrl} | alu_a, 0);
      @(posedge clk); #1;
      chk("bp_hold", {rsp_data[26:0], rsp_valid, rsp_tag},
          {27'd7, 1'b1, 4'd9});
      chk("bp_id", {31'd0, rsp_id}, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {30'd0, req0_ready, req1_ready}, 1);
    @(posedge clk); #1;
    chk("bp_new_data", rsp_data, 32'hFF);
    chk("bp_new_meta", {26'd0, rsp_valid, rsp_id, rsp_tag},
        {26'd0, 1'b1, 1'b1, 4'd10});

    // asynchronous reset with a held response
    @(negedge clk);
    drive(0,0,0,0,0, 0,0,0,0,0, 0);
    #1;
    chk("ar_pre_valid", {31'd0, rsp_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, rsp_valid}, 0);
    chk("ar_data", rsp_data, 0);
    drive(1,1,1,0,1, 1,1,4,2,2, 1);
    #1;
    chk("ar_no_grant", {30'd0, req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_first_rdy", {30'd0, req0_ready, req1_ready}, 2);
    @(posedge clk); #1;
    chk("ar_first_rsp", {26'd0, rsp_valid, rsp_id, rsp_tag},
        {26'd0, 1'b1, 1'b0, 4'd1});
    chk("ar_first_data", rsp_data, 2);

    @(negedge clk);
    drive(0,0,0,0,0, 0,0,0,0,0, 1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
